reg_bank_writer: RTL

Write side of the integer register file: a 32-entry × WIDTH register bank with a decoded write port, hardwired-zero x0, and a per-register pending-write scoreboard. It takes the write-back stage's destination address and data, updates exactly one register per cycle, and drives all 32 register values in parallel to the 32:1 read-port multiplexers in decode. The scoreboard tracks registers with an in-flight producer so the hazard unit can stall.

---
 rtl/reg_bank_writer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_bank_writer.sv
// Write side of the integer register file: 32 x WIDTH bank with a decoded write
// port, hardwired-zero x0 and a per-register pending-write scoreboard.
module reg_bank_writer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WrEn,
    input  logic [4:0]       WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             IssueEn,
    input  logic [4:0]       IssueAddr,
    output logic [WIDTH-1:0] Dout0,
    output logic [WIDTH-1:0] Dout1,
    output logic [WIDTH-1:0] Dout2,
    output logic [WIDTH-1:0] Dout3,
    output logic [WIDTH-1:0] Dout4,
    output logic [WIDTH-1:0] Dout5,
    output logic [WIDTH-1:0] Dout6,
    output logic [WIDTH-1:0] Dout7,
    output logic [WIDTH-1:0] Dout8,
    output logic [WIDTH-1:0] Dout9,
    output logic [WIDTH-1:0] Dout10,
    output logic [WIDTH-1:0] Dout11,
    output logic [WIDTH-1:0] Dout12,
    output logic [WIDTH-1:0] Dout13,
    output logic [WIDTH-1:0] Dout14,
    output logic [WIDTH-1:0] Dout15,
    output logic [WIDTH-1:0] Dout16,
    output logic [WIDTH-1:0] Dout17,
    output logic [WIDTH-1:0] Dout18,
    output logic [WIDTH-1:0] Dout19,
    output logic [WIDTH-1:0] Dout20,
    output logic [WIDTH-1:0] Dout21,
    output logic [WIDTH-1:0] Dout22,
    output logic [WIDTH-1:0] Dout23,
    output logic [WIDTH-1:0] Dout24,
    output logic [WIDTH-1:0] Dout25,
    output logic [WIDTH-1:0] Dout26,
    output logic [WIDTH-1:0] Dout27,
    output logic [WIDTH-1:0] Dout28,
    output logic [WIDTH-1:0] Dout29,
    output logic [WIDTH-1:0] Dout30,
    output logic [WIDTH-1:0] Dout31,
    output logic [31:0]      Busy
);

    logic [WIDTH-1:0] regs [31:1];
    logic [31:1]      busy_q;
    logic [31:0]      wr_sel;
    logic [31:0]      issue_sel;

    // x0 never gets an enable, so it needs no storage at all
    always_comb begin
        wr_sel    = '0;
        issue_sel = '0;
        if (WrEn)
            wr_sel[WrAddr] = 1'b1;
        if (IssueEn)
            issue_sel[IssueAddr] = 1'b1;
        wr_sel[0]    = 1'b0;
        issue_sel[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (rst)
                regs[i] <= '0;
            else if (wr_sel[i])
                regs[i] <= WrData;
        end
    end

    // A new producer wins over a retiring one in the same cycle
    always_ff @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (rst)
                busy_q[i] <= 1'b0;
            else if (issue_sel[i])
                busy_q[i] <= 1'b1;
            else if (wr_sel[i])
                busy_q[i] <= 1'b0;
        end
    end

    assign Busy   = {busy_q, 1'b0};

    assign Dout0  = '0;
    assign Dout1  = regs[1];
    assign Dout2  = regs[2];
    assign Dout3  = regs[3];
    assign Dout4  = regs[4];
    assign Dout5  = regs[5];
    assign Dout6  = regs[6];
    assign Dout7  = regs[7];
    assign Dout8  = regs[8];
    assign Dout9  = regs[9];
    assign Dout10 = regs[10];
    assign Dout11 = regs[11];
    assign Dout12 = regs[12];
    assign Dout13 = regs[13];
    assign Dout14 = regs[14];
    assign Dout15 = regs[15];
    assign Dout16 = regs[16];
    assign Dout17 = regs[17];
    assign Dout18 = regs[18];
    assign Dout19 = regs[19];
    assign Dout20 = regs[20];
    assign Dout21 = regs[21];
    assign Dout22 = regs[22];
    assign Dout23 = regs[23];
    assign Dout24 = regs[24];
    assign Dout25 = regs[25];
    assign Dout26 = regs[26];
    assign Dout27 = regs[27];
    assign Dout28 = regs[28];
    assign Dout29 = regs[29];
    assign Dout30 = regs[30];
    assign Dout31 = regs[31];

endmodule
